// File: rtl/sw_target_feeder.sv
// sw_target_feeder
//   Front-end sequencer for the Smith-Waterman scoring array. Takes one
//   alignment job (query, qlen, tlen), pulses the array reset for two cycles,
//   serializes packed target words into one 2-bit base per cycle, waits for
//   the array's registered vld (bounded by DRAIN_MAX) and hands the score
//   back on a valid/ready result port.
//
// Ports
//   clk, rst                      clock, synchronous active-low reset
//   job_valid/job_ready           job handshake: job_query, job_qlen, job_tlen
//   tgt_valid/tgt_ready/tgt_data  packed target words, LSB base first
//   sc_rst, sc_en, sc_data        array reset (active low), en_in, data_in
//   sc_query, sc_select           array query and output_select, held per job
//   sc_result, sc_vld             array score and its valid
//   res_valid/res_ready           result handshake: res_score, res_underrun,
//                                 res_timeout
//   perf_cycles                   accept-to-result cycle count
//
// Build option
//   SW_FEEDER_PERF_EN : when defined, perf_cycles counts cycles from job
//                       accept to the res_valid rise (saturating). When
//                       undefined, perf_cycles is tied to zero.
module sw_target_feeder #(
  parameter int SCORE_WIDTH = 12,
  parameter int LENGTH      = 128,
  parameter int LOG_LENGTH  = 8,
  parameter int WORD_BASES  = 32,
  parameter int LEN_WIDTH   = 16,
  parameter int DRAIN_MAX   = LENGTH + 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic [2*LENGTH-1:0]     job_query,
  input  logic [LOG_LENGTH-1:0]   job_qlen,
  input  logic [LEN_WIDTH-1:0]    job_tlen,
  input  logic                    tgt_valid,
  output logic                    tgt_ready,
  input  logic [2*WORD_BASES-1:0] tgt_data,
  output logic                    sc_rst,
  output logic                    sc_en,
  output logic [1:0]              sc_data,
  output logic [2*LENGTH-1:0]     sc_query,
  output logic [LOG_LENGTH-1:0]   sc_select,
  input  logic [SCORE_WIDTH-1:0]  sc_result,
  input  logic                    sc_vld,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [SCORE_WIDTH-1:0]  res_score,
  output logic                    res_underrun,
  output logic                    res_timeout,
  output logic [31:0]             perf_cycles
);

  localparam int IDX_W = (WORD_BASES > 1) ? $clog2(WORD_BASES) : 1;
  localparam int TMR_W = $clog2(DRAIN_MAX + 1);
  // Biased score representing zero.
  localparam logic [SCORE_WIDTH-1:0] SCORE_ZERO = {1'b1, {(SCORE_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t                  state, state_nx;
  logic                    clr_cnt;   // second CLEAR cycle
  logic [LEN_WIDTH-1:0]    rem;       // bases still to emit
  logic [2*WORD_BASES-1:0] wbuf;      // word being serialized
  logic [IDX_W-1:0]        widx;      // next base of wbuf to emit
  logic                    wfull;     // wbuf still has unemitted bases
  logic                    started;   // first base of the job emitted
  logic [TMR_W-1:0]        tmr;

  logic                    job_take, tgt_take, feed, have, last_base;
  logic [2*WORD_BASES-1:0] src_word;
  logic [IDX_W-1:0]        src_idx;
  logic [1:0]              src_base;
  logic [LEN_WIDTH-1:0]    rem_dec;

  // Serializer source: buffered word if it still holds bases, otherwise a
  // word arriving this cycle is emitted straight away (base 0) so that a new
  // word adds no bubble. The last CLEAR cycle already feeds, which puts the
  // first base on sc_data at accept + 3.
  always_comb begin
    job_take  = job_valid && job_ready;
    tgt_take  = tgt_valid && tgt_ready;
    feed      = ((state == S_STREAM) || (state == S_CLEAR && clr_cnt)) && (rem != '0);
    src_word  = wfull ? wbuf : tgt_data;
    src_idx   = wfull ? widx : '0;
    have      = feed && (wfull || tgt_take);
    src_base  = src_word[{src_idx, 1'b0} +: 2];
    last_base = (src_idx == IDX_W'(WORD_BASES - 1));
    rem_dec   = rem - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (job_take) state_nx = S_CLEAR;
      S_CLEAR:  if (clr_cnt) begin
                  if (rem == '0)                    state_nx = S_DONE;
                  else if (have && rem_dec == '0)   state_nx = S_DRAIN;
                  else                              state_nx = S_STREAM;
                end
      S_STREAM: if (have && rem_dec == '0) state_nx = S_DRAIN;
      S_DRAIN:  if (sc_vld || tmr == TMR_W'(DRAIN_MAX - 1)) state_nx = S_DONE;
      S_DONE:   if (res_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      job_ready    <= 1'b0;
      tgt_ready    <= 1'b0;
      sc_rst       <= 1'b0;
      sc_en        <= 1'b0;
      sc_data      <= '0;
      sc_query     <= '0;
      sc_select    <= '0;
      res_valid    <= 1'b0;
      res_score    <= '0;
      res_underrun <= 1'b0;
      res_timeout  <= 1'b0;
      clr_cnt      <= 1'b0;
      rem          <= '0;
      wbuf         <= '0;
      widx         <= '0;
      wfull        <= 1'b0;
      started      <= 1'b0;
      tmr          <= '0;
    end else begin
      job_ready <= (state_nx == S_IDLE);
      sc_rst    <= (state_nx != S_CLEAR);
      res_valid <= (state_nx == S_DONE);
      tgt_ready <= 1'b0;
      sc_en     <= 1'b0;
      tmr       <= '0;

      case (state)
        S_IDLE: if (job_take) begin
          sc_query     <= job_query;
          sc_select    <= (job_qlen == '0) ? LOG_LENGTH'(1) : job_qlen;
          rem          <= job_tlen;
          res_underrun <= 1'b0;
          res_timeout  <= 1'b0;
          clr_cnt      <= 1'b0;
          wfull        <= 1'b0;
          started      <= 1'b0;
        end
        S_CLEAR: begin
          clr_cnt <= 1'b1;
          // Open the target port one cycle ahead so a word can land on the
          // last CLEAR cycle; an empty target skips streaming entirely.
          if (!clr_cnt)        tgt_ready <= (rem != '0);
          else if (rem == '0)  res_score <= SCORE_ZERO;
        end
        S_DRAIN: begin
          tmr <= tmr + 1'b1;
          // A vld coinciding with the last timer cycle still wins.
          if (sc_vld) begin
            res_score <= sc_result;
          end else if (tmr == TMR_W'(DRAIN_MAX - 1)) begin
            res_timeout <= 1'b1;
            res_score   <= SCORE_ZERO;
          end
        end
        default: ;
      endcase

      if (feed) begin
        if (have) begin
          sc_en   <= 1'b1;
          sc_data <= src_base;
          rem     <= rem_dec;
          started <= 1'b1;
          wbuf    <= src_word;
          widx    <= src_idx + 1'b1;
          // Trailing bases of the final word are dropped with the buffer.
          wfull     <= !last_base && (rem_dec != '0);
          tgt_ready <= last_base && (rem_dec != '0);
        end else begin
          // Starved: sc_data keeps its last value, port stays open.
          tgt_ready <= 1'b1;
          if (started) res_underrun <= 1'b1;
        end
      end
    end
  end

`ifdef SW_FEEDER_PERF_EN
  logic [31:0] perf_q;

  // Loaded with 1 on accept so the value seen at the res_valid rise equals
  // the number of cycles from the accept cycle to that rise.
  always_ff @(posedge clk) begin
    if (!rst)
      perf_q <= '0;
    else if (job_take)
      perf_q <= 32'd1;
    else if ((state == S_CLEAR || state == S_STREAM || state == S_DRAIN) && perf_q != '1)
      perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_sw_target_feeder.sv
// Randomized bench for sw_target_feeder. Each job is checked against a
// rule-level model: the base stream is the first tlen bases of the offered
// words, stall cycles equal the injected source gaps, and latencies follow
// from accept (+3 to first base) and last base (+vld delay+1 or +DRAIN_MAX).
module tb_sw_target_feeder;
  localparam int SW = 12;
  localparam int LN = 128;
  localparam int LL = 8;
  localparam int WB = 32;
  localparam int LW = 16;
  localparam int DM = LN + 8;
  localparam logic [SW-1:0] ZERO_SC = 12'h800;

  logic clk = 1'b0;
  logic rst;
  logic job_valid, job_ready;
  logic [2*LN-1:0] job_query;
  logic [LL-1:0] job_qlen;
  logic [LW-1:0] job_tlen;
  logic tgt_valid, tgt_ready;
  logic [2*WB-1:0] tgt_data;
  logic sc_rst, sc_en;
  logic [1:0] sc_data;
  logic [2*LN-1:0] sc_query;
  logic [LL-1:0] sc_select;
  logic [SW-1:0] sc_result;
  logic sc_vld;
  logic res_valid, res_ready;
  logic [SW-1:0] res_score;
  logic res_underrun, res_timeout;
  logic [31:0] perf_cycles;

  always #5 clk = ~clk;

  sw_target_feeder dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_query(job_query),
    .job_qlen(job_qlen), .job_tlen(job_tlen),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt_data(tgt_data),
    .sc_rst(sc_rst), .sc_en(sc_en), .sc_data(sc_data), .sc_query(sc_query),
    .sc_select(sc_select), .sc_result(sc_result), .sc_vld(sc_vld),
    .res_valid(res_valid), .res_ready(res_ready), .res_score(res_score),
    .res_underrun(res_underrun), .res_timeout(res_timeout),
    .perf_cycles(perf_cycles)
  );

  int checks = 0;
  int errors = 0;
  int gap [8];                 // gap[k]: ready-high cycles withheld before word k
  logic [2*WB-1:0] words [$];

  task automatic chk(input string tag, input logic [2*LN-1:0] obs, input logic [2*LN-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_job_ready"}, job_ready, 0);
    chk({t, "_tgt_ready"}, tgt_ready, 0);
    chk({t, "_sc_rst"}, sc_rst, 0);
    chk({t, "_sc_en"}, sc_en, 0);
    chk({t, "_sc_data"}, sc_data, 0);
    chk({t, "_sc_query"}, sc_query, 0);
    chk({t, "_sc_select"}, sc_select, 0);
    chk({t, "_res_valid"}, res_valid, 0);
    chk({t, "_res_score"}, res_score, 0);
    chk({t, "_res_underrun"}, res_underrun, 0);
    chk({t, "_res_timeout"}, res_timeout, 0);
    chk({t, "_perf"}, perf_cycles, 0);
  endtask

  // vdly < 0: array never raises vld. rst_at >= 0: pull rst low while base
  // rst_at is on sc_data and abandon the job.
  task automatic run_job(input int qlen, input int tlen, input int vdly, input int rdly,
                         input int rst_at, input logic [SW-1:0] score);
    logic [2*LN-1:0] q;
    logic [2*WB-1:0] w;
    logic [SW-1:0] exp_sc, h_sc;
    logic h_u, h_t;
    int nw, wi, gcnt, acc, first, last, rise, nen, lows, mism, rlow, jrhi, chg, gsum, exp_rise;
    bit done, exp_to;
    nw = (tlen + WB - 1) / WB;
    words.delete();
    for (int i = 0; i <= nw; i++) words.push_back({$urandom, $urandom});
    for (int i = 0; i < 2*LN/32; i++) q[32*i +: 32] = $urandom;
    gsum = 0;
    for (int k = 1; k < nw; k++) gsum += gap[k];
    wi = 0; gcnt = gap[0]; acc = -1; first = -1; last = -1; rise = -1;
    nen = 0; lows = 0; mism = 0; rlow = 0; jrhi = 0; chg = 0; done = 0;
    h_sc = '0; h_u = 0; h_t = 0;
    res_ready = 0; sc_vld = 0; sc_result = score;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (acc < 0) begin
        job_valid = 1; job_query = q; job_qlen = LL'(qlen); job_tlen = LW'(tlen);
        if (job_ready) acc = c;
      end else begin
        job_valid = 0; job_query = {8{$urandom}}; job_qlen = LL'($urandom); job_tlen = LW'($urandom);
        if (!sc_rst) rlow++;
        if (job_ready) jrhi++;
        if (sc_en) begin
          if (nen < tlen) begin
            w = words[nen / WB];
            if (sc_data !== w[2*(nen % WB) +: 2]) mism++;
          end else mism++;
          if (first < 0) first = c; else lows += c - last - 1;
          last = c; nen++;
          if (rst_at >= 0 && nen == rst_at + 1) begin
            rst = 0; tgt_valid = 0;
            @(negedge clk);
            chk_reset("rst_mid");
            rst = 1;
            @(negedge clk);
            chk("rst_rel_job_ready", job_ready, 1);
            chk("rst_rel_sc_rst", sc_rst, 1);
            return;
          end
        end
        if (res_valid) begin
          if (rise < 0) begin
            rise = c; h_sc = res_score; h_u = res_underrun; h_t = res_timeout;
`ifdef SW_FEEDER_PERF_EN
            chk("perf", perf_cycles, rise - acc);
`else
            chk("perf", perf_cycles, 0);
`endif
            chk("select", sc_select, (qlen == 0) ? 1 : qlen);
            chk("query", sc_query, q);
          end else if (res_score !== h_sc || res_underrun !== h_u || res_timeout !== h_t) chg++;
        end
      end
      // target source
      if (gcnt > 0) begin
        tgt_valid = 0;
        if (tgt_ready) gcnt--;
      end else tgt_valid = (wi <= nw);
      tgt_data = (wi <= nw) ? words[wi] : '0;
      if (tgt_valid && tgt_ready) begin
        wi++;
        gcnt = (wi < 8) ? gap[wi] : 0;
      end
      // array and host
      sc_vld = (rise < 0 && vdly >= 0 && tlen > 0 && nen == tlen && c >= last + vdly);
      res_ready = (rise >= 0 && c >= rise + rdly);
      if (res_valid && res_ready) done = 1;
    end
    tgt_valid = 0; sc_vld = 0;
    chk("budget", done, 1);
    if (tlen == 0) begin
      exp_rise = acc + 3; exp_to = 0; exp_sc = ZERO_SC;
    end else if (vdly >= 0 && vdly <= DM - 1) begin
      exp_rise = last + vdly + 1; exp_to = 0; exp_sc = score;
    end else begin
      exp_rise = last + DM; exp_to = 1; exp_sc = ZERO_SC;
    end
    chk("sc_rst_low", rlow, 2);
    chk("job_ready_busy", jrhi, 0);
    chk("en_count", nen, tlen);
    chk("bases", mism, 0);
    chk("words_taken", wi, nw);
    if (tlen > 0) begin
      chk("first_lat", first - acc, 3 + gap[0]);
      chk("stalls", lows, gsum);
    end
    chk("rise", rise, exp_rise);
    chk("score", h_sc, exp_sc);
    chk("underrun", h_u, (gsum > 0) ? 1 : 0);
    chk("timeout", h_t, exp_to);
    chk("hold", chg, 0);
    @(negedge clk);
    res_ready = 0;
    chk("back_idle", job_ready, 1);
    chk("valid_drop", res_valid, 0);
  endtask

  initial begin
    rst = 0; job_valid = 0; job_query = '0; job_qlen = '0; job_tlen = '0;
    tgt_valid = 0; tgt_data = '0; sc_result = '0; sc_vld = 0; res_ready = 0;
    foreach (gap[i]) gap[i] = 0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst = 1;
    @(negedge clk);
    chk("idle_job_ready", job_ready, 1);
    chk("idle_sc_rst", sc_rst, 1);

    run_job(4, 8, 2, 0, -1, 12'h80A);          // single word
    run_job(16, 40, 0, 1, -1, 12'h3C1);        // back-to-back words, tail discarded
    gap[1] = 3;
    run_job(128, 64, 3, 0, -1, 12'h7FF);       // 3-cycle underrun
    gap[1] = 0;
    run_job(7, 0, 0, 0, -1, 12'h111);          // empty target
    run_job(0, 20, -1, 5, -1, 12'h222);        // timeout, qlen clamp, held result
    run_job(9, 33, DM - 1, 0, -1, 12'h123);    // vld on the expiring cycle
    run_job(9, 33, DM, 0, -1, 12'h456);        // vld one cycle too late
    gap[0] = 2;
    run_job(31, 5, 1, 0, -1, 12'h0A5);         // late first word, no underrun
    gap[0] = 0;
    run_job(50, 64, 0, 0, 10, 12'h333);        // reset mid-stream
    run_job(3, 32, 1, 2, -1, 12'h444);         // clean job after reset

    for (int j = 0; j < 12; j++) begin
      foreach (gap[i]) gap[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_job(int'($urandom_range(0, LN)), int'($urandom_range(0, 200)),
              ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 12)),
              int'($urandom_range(0, 3)), -1, SW'($urandom));
    end
    foreach (gap[i]) gap[i] = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
